// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared constants and helpers for fifo_param.
//   SEG7_HEX    : 16-entry hex font for a common-anode, active-low seven-segment
//                 digit. Each entry is ordered abcdefg, with a at bit 6.
//   SEG7_ALL_ON : every segment lit. This is the digit pattern after reset.
//   seg7()      : converts a nibble to its segment pattern.
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam logic [6:0] SEG7_ALL_ON = 7'b0000000;

    // Packed array: index 0 is the rightmost element of the concatenation.
    localparam logic [15:0][6:0] SEG7_HEX = {
        7'b0111000,  // F
        7'b0110000,  // E
        7'b1000010,  // d
        7'b0110001,  // C
        7'b1100000,  // b
        7'b0001000,  // A
        7'b0000100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

    function automatic logic [6:0] seg7(input logic [3:0] nibble);
        return SEG7_HEX[nibble];
    endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// -----------------------------------------------------------------------------
// seg7_hex_dec
// Combinational lookup from a nibble to seven-segment patterns. The output is
// active-low and ordered abcdefg.
//   nibble : input  [3:0] hex value to display
//   seg    : output [6:0] segment pattern
// -----------------------------------------------------------------------------
module seg7_hex_dec
    import fifo_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = seg7(nibble);

endmodule

// File: rtl/fifo_param.sv
// -----------------------------------------------------------------------------
// fifo_param
// Parametrised synchronous FIFO.
//   - A true full condition occurs at DEPTH entries.
//   - Read data is registered and qualified by rd_valid.
//   - The block provides almost-full and almost-empty thresholds, an occupancy
//     count, and sticky overflow and underflow flags.
//
// Optional feature (macro FIFO_SEG7_EN): a registered hex seven-segment
// driver. It shows the low nibble of the last word read.
//
// Ports:
//   clock, reset        : system clock (rising edge) and async active-high reset
//   wr_en, wr_data      : write request and write data
//   rd_en               : read request
//   rd_data, rd_valid   : registered read data and its one-cycle valid pulse
//   fifo_empty/full     : occupancy is 0 / DEPTH
//   almost_empty/full   : occupancy <= AEMPTY_TH / occupancy >= AFULL_TH
//   fill_count          : current occupancy (0..DEPTH)
//   overflow, underflow : sticky error flags, cleared by clr_err
//   clr_err             : synchronous clear of both error flags
//   digitron_out        : segments abcdefg, active-low (FIFO_SEG7_EN only)
//   digitron_select     : digit enable, active-low, held 0 (FIFO_SEG7_EN only)
// -----------------------------------------------------------------------------
module fifo_param
    import fifo_pkg::*;
#(
    parameter  int WIDTH     = 4,
    parameter  int DEPTH     = 128,
    parameter  int AFULL_TH  = 120,
    parameter  int AEMPTY_TH = 8,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic              clr_err,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   fill_count,
    output logic              overflow,
    output logic              underflow
`ifdef FIFO_SEG7_EN
    ,
    output logic [6:0]        digitron_out,
    output logic              digitron_select
`endif
);

    localparam int CNT_W = ADDR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_TH);

    logic [WIDTH-1:0]  mem [0:DEPTH-1];

    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic [WIDTH-1:0]  rd_data_reg;
    logic              rd_valid_reg;
    logic              overflow_reg;
    logic              underflow_reg;

    logic              wr_ok;
    logic              rd_ok;
    logic [WIDTH-1:0]  rd_word;

    // Flags decode directly from the registered count, so they carry no lag.
    assign fifo_empty   = (count_reg == '0);
    assign fifo_full    = (count_reg == DEPTH_C);
    assign almost_empty = (count_reg <= AEMPTY_C);
    assign almost_full  = (count_reg >= AFULL_C);

    // A full FIFO still accepts a write when a read frees a slot on the same
    // edge. An empty FIFO never forwards write data to the read port.
    assign rd_ok = rd_en & ~fifo_empty;
    assign wr_ok = wr_en & (~fifo_full | rd_ok);

    assign rd_word = mem[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        if (wr_ok && !rd_ok) begin
            count_next = count_reg + CNT_W'(1);
        end else if (rd_ok && !wr_ok) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    // The storage array has no reset, so it can map onto block RAM.
    always_ff @(posedge clock) begin
        if (wr_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // The pointers wrap naturally at DEPTH because DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            rd_data_reg   <= '0;
            rd_valid_reg  <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            count_reg    <= count_next;
            rd_valid_reg <= rd_ok;
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr_reg  <= rd_ptr_reg + ADDR_W'(1);
                rd_data_reg <= rd_word;
            end
            // A clear wins over an error raised on the same edge.
            if (clr_err) begin
                overflow_reg  <= 1'b0;
                underflow_reg <= 1'b0;
            end else begin
                if (wr_en && !wr_ok) begin
                    overflow_reg <= 1'b1;
                end
                if (rd_en && !rd_ok) begin
                    underflow_reg <= 1'b1;
                end
            end
        end
    end

    assign rd_data    = rd_data_reg;
    assign rd_valid   = rd_valid_reg;
    assign fill_count = count_reg;
    assign overflow   = overflow_reg;
    assign underflow  = underflow_reg;

`ifdef FIFO_SEG7_EN
    logic [6:0] seg_next;
    logic [6:0] digitron_reg;

    // The decoder sees the word being loaded into rd_data. The digit register
    // therefore updates on the same edge as rd_data.
    seg7_hex_dec u_seg7_hex_dec (
        .nibble (rd_word[3:0]),
        .seg    (seg_next)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            digitron_reg <= SEG7_ALL_ON;
        end else if (rd_ok) begin
            digitron_reg <= seg_next;
        end
    end

    assign digitron_out    = digitron_reg;
    assign digitron_select = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_fifo_param
// Self-checking bench for fifo_param with its default parameters (WIDTH=4,
// DEPTH=128, AFULL_TH=120, AEMPTY_TH=8).
// -----------------------------------------------------------------------------
module tb_fifo_param;

    localparam int WIDTH  = 4;
    localparam int DEPTH  = 128;
    localparam int ADDR_W = 7;

    logic              clock = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [WIDTH-1:0]  wr_data;
    logic              rd_en;
    logic              clr_err;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_valid;
    logic              fifo_empty;
    logic              fifo_full;
    logic              almost_empty;
    logic              almost_full;
    logic [ADDR_W:0]   fill_count;
    logic              overflow;
    logic              underflow;
`ifdef FIFO_SEG7_EN
    logic [6:0]        digitron_out;
    logic              digitron_select;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    fifo_param dut (
        .clock        (clock),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .clr_err      (clr_err),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .fill_count   (fill_count),
        .overflow     (overflow),
        .underflow    (underflow)
`ifdef FIFO_SEG7_EN
        ,
        .digitron_out    (digitron_out),
        .digitron_select (digitron_select)
`endif
    );

    // Reference font for the expected digit, written out independently.
    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;  default: return 7'b0111000;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic w, input logic [3:0] d, input logic r, input logic c);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        clr_err = c;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " rd_data"},      int'(rd_data), 0);
        chk({tag, " rd_valid"},     int'(rd_valid), 0);
        chk({tag, " fill_count"},   int'(fill_count), 0);
        chk({tag, " fifo_empty"},   int'(fifo_empty), 1);
        chk({tag, " fifo_full"},    int'(fifo_full), 0);
        chk({tag, " almost_empty"}, int'(almost_empty), 1);
        chk({tag, " almost_full"},  int'(almost_full), 0);
        chk({tag, " overflow"},     int'(overflow), 0);
        chk({tag, " underflow"},    int'(underflow), 0);
`ifdef FIFO_SEG7_EN
        chk({tag, " digitron_out"},    int'(digitron_out), 0);
        chk({tag, " digitron_select"}, int'(digitron_select), 0);
`endif
    endtask

    // ---------------- table-driven vectors ----------------
    typedef struct {
        logic       wr;
        logic [3:0] din;
        logic       rd;
        logic       clr;
        logic       e_valid;
        logic [3:0] e_data;
        int         e_count;
        logic       e_ovf;
        logic       e_unf;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [0:NVEC-1];

    function automatic vec_t mk(input logic wr, input logic [3:0] din, input logic rd,
                                input logic clr, input logic ev, input logic [3:0] ed,
                                input int ec, input logic eo, input logic eu);
        vec_t v;
        v.wr = wr; v.din = din; v.rd = rd; v.clr = clr;
        v.e_valid = ev; v.e_data = ed; v.e_count = ec; v.e_ovf = eo; v.e_unf = eu;
        return v;
    endfunction

    // ---------------- queue model for the long sequences ----------------
    logic [3:0] q[$];
    int         m_count = 0;
    logic       m_ovf   = 1'b0;
    logic       m_unf   = 1'b0;

    task automatic mstep(input string tag, input logic w, input logic [3:0] d,
                         input logic r, input logic c);
        logic       acc_rd;
        logic       acc_wr;
        logic [3:0] exp_d;
        exp_d  = '0;
        acc_rd = r && (m_count > 0);
        acc_wr = w && ((m_count < DEPTH) || acc_rd);
        if (c) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (w && !acc_wr) m_ovf = 1'b1;
            if (r && !acc_rd) m_unf = 1'b1;
        end
        if (acc_rd) exp_d = q.pop_front();
        if (acc_wr) q.push_back(d);
        if (acc_wr && !acc_rd) m_count++;
        else if (acc_rd && !acc_wr) m_count--;
        cyc(w, d, r, c);
        $display("%s wr=%b d=%h rd=%b clr=%b -> valid=%b data=%h count=%0d ovf=%b unf=%b",
                 tag, w, d, r, c, rd_valid, rd_data, fill_count, overflow, underflow);
        chk({tag, " rd_valid"}, int'(rd_valid), int'(acc_rd));
        if (acc_rd) begin
            chk({tag, " rd_data"}, int'(rd_data), int'(exp_d));
`ifdef FIFO_SEG7_EN
            chk({tag, " digitron_out"}, int'(digitron_out), int'(ref_seg(exp_d)));
`endif
        end
        chk({tag, " fill_count"},   int'(fill_count), m_count);
        chk({tag, " fifo_full"},    int'(fifo_full), int'(m_count == DEPTH));
        chk({tag, " fifo_empty"},   int'(fifo_empty), int'(m_count == 0));
        chk({tag, " almost_full"},  int'(almost_full), int'(m_count >= 120));
        chk({tag, " almost_empty"}, int'(almost_empty), int'(m_count <= 8));
        chk({tag, " overflow"},     int'(overflow), int'(m_ovf));
        chk({tag, " underflow"},    int'(underflow), int'(m_unf));
    endtask

    initial begin
        logic [3:0] last_seg_nib;
        logic       seg_loaded;
        last_seg_nib = '0;
        seg_loaded   = 1'b0;

        // Write 1..8, read eight times, idle, then run the empty wr+rd corner.
        for (int i = 0; i < 8; i++)
            vecs[i] = mk(1'b1, 4'(i + 1), 1'b0, 1'b0, 1'b0, 4'h0, i + 1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            vecs[8 + i] = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'(i + 1), 7 - i, 1'b0, 1'b0);
        vecs[16] = mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h8, 0, 1'b0, 1'b0);
        vecs[17] = mk(1'b1, 4'hA, 1'b1, 1'b0, 1'b0, 4'h8, 1, 1'b0, 1'b1);
        vecs[18] = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'hA, 0, 1'b0, 1'b1);
        vecs[19] = mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'hA, 0, 1'b0, 1'b0);

        reset = 1'b1; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; clr_err = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk_reset_values("reset");
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            cyc(vecs[i].wr, vecs[i].din, vecs[i].rd, vecs[i].clr);
            $display("vec %0d wr=%b d=%h rd=%b clr=%b -> valid=%b data=%h count=%0d ovf=%b unf=%b",
                     i, vecs[i].wr, vecs[i].din, vecs[i].rd, vecs[i].clr,
                     rd_valid, rd_data, fill_count, overflow, underflow);
            chk($sformatf("vec%0d rd_valid", i), int'(rd_valid), int'(vecs[i].e_valid));
            chk($sformatf("vec%0d rd_data", i), int'(rd_data), int'(vecs[i].e_data));
            chk($sformatf("vec%0d fill_count", i), int'(fill_count), vecs[i].e_count);
            chk($sformatf("vec%0d fifo_empty", i), int'(fifo_empty), int'(vecs[i].e_count == 0));
            chk($sformatf("vec%0d fifo_full", i), int'(fifo_full), 0);
            chk($sformatf("vec%0d almost_empty", i), int'(almost_empty), int'(vecs[i].e_count <= 8));
            chk($sformatf("vec%0d overflow", i), int'(overflow), int'(vecs[i].e_ovf));
            chk($sformatf("vec%0d underflow", i), int'(underflow), int'(vecs[i].e_unf));
            if (vecs[i].e_valid) begin
                last_seg_nib = vecs[i].e_data;
                seg_loaded   = 1'b1;
            end
`ifdef FIFO_SEG7_EN
            chk($sformatf("vec%0d digitron_out", i), int'(digitron_out),
                seg_loaded ? int'(ref_seg(last_seg_nib)) : 0);
`endif
        end

        // Fill to DEPTH, then make one more write that must be rejected.
        for (int i = 0; i < DEPTH; i++)
            mstep($sformatf("fill%0d", i), 1'b1, 4'(i * 5 + 1), 1'b0, 1'b0);
        mstep("extra_wr", 1'b1, 4'hF, 1'b0, 1'b0);

        // Clear the error, then write and read together while full.
        mstep("clr", 1'b0, 4'h0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++)
            mstep($sformatf("full_wr_rd%0d", i), 1'b1, 4'(i + 3), 1'b1, 1'b0);

        // Drain the FIFO. The read pointer crosses 127 -> 0.
        for (int i = 0; i < DEPTH; i++)
            mstep($sformatf("drain%0d", i), 1'b0, 4'h0, 1'b1, 1'b0);

        // Assert reset between edges during a write burst.
        for (int i = 0; i < 50; i++)
            mstep($sformatf("burst%0d", i), 1'b1, 4'(i), 1'b0, 1'b0);
        wr_en = 1'b0;
        #3 reset = 1'b1;
        #1;
        $display("async reset asserted mid-burst: count=%0d empty=%b", fill_count, fifo_empty);
        chk_reset_values("async_reset");
        q.delete();
        m_count = 0; m_ovf = 1'b0; m_unf = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
        mstep("post_reset_idle", 1'b0, 4'h0, 1'b0, 1'b0);
        mstep("post_reset_rd", 1'b0, 4'h0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
